v_mult_accum: RTL and testbench

- Stage directly downstream of the pipelined 18x18 unsigned multiplier (36-bit product, 5-cycle latency).
- Delays the caller's VALID/LAST sideband so that it lines up with the product stream.
- Accumulates the products of a frame, for example a dot product.
- At the end of each frame, emits a registered sum, a term count and an overflow flag.

---
 rtl/v_mult_pkg.sv | 31 +++
 rtl/v_valid_delay.sv | 37 +++
 rtl/v_mult_accum.sv | 90 +++++++++
 tb/tb_v_mult_accum.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/v_mult_pkg.sv
// ============================================================================
// v_mult_pkg : shared constants and sideband type for the multiply-accumulate
// Rev 1.0
// ============================================================================
`default_nettype none

package v_mult_pkg;

  localparam int MULT_LATENCY = 5;
  localparam int MULT_PROD_W  = 36;
  localparam int MULT_ACC_W   = 48;
  localparam int MULT_CNT_W   = 16;

  typedef struct packed {
    logic valid;
    logic last;
  } sideband_t;

  localparam sideband_t SB_IDLE = '{valid: 1'b0, last: 1'b0};

  // LAST only means something when qualified by VALID.
  function automatic sideband_t make_sb(input logic valid, input logic last);
    sideband_t sb;
    sb.valid = valid;
    sb.last  = valid & last;
    return sb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/v_valid_delay.sv
// ============================================================================
// v_valid_delay : LATENCY-deep {valid,last} shift register, synchronous clear
// Rev 1.0
// ============================================================================
`default_nettype none

module v_valid_delay
  import v_mult_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY
) (
  input  logic      clk,
  input  logic      rst,
  input  sideband_t din,
  output sideband_t dout
);

  sideband_t stage [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage[i] <= SB_IDLE;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/v_mult_accum.sv
// ============================================================================
// v_mult_accum : aligns caller sideband with multiplier output, accumulates
//                saturating frame sums and emits sum/count/overflow per frame
// Rev 1.0
// ============================================================================
`default_nettype none

module v_mult_accum
  import v_mult_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY,
  parameter int PROD_W  = MULT_PROD_W,
  parameter int ACC_W   = MULT_ACC_W,
  parameter int CNT_W   = MULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IN_VALID,
  input  logic              IN_LAST,
  input  logic [PROD_W-1:0] MULT,
  output logic [ACC_W-1:0]  SUM,
  output logic [CNT_W-1:0]  SUM_CNT,
  output logic              SUM_OVF,
  output logic              SUM_VALID
);

  sideband_t in_sb;
  sideband_t aligned_sb;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W:0]   nsum;
  logic             sat;
  logic [ACC_W-1:0] value;
  logic [CNT_W-1:0] ncnt;

  assign in_sb = make_sb(IN_VALID, IN_LAST);

  v_valid_delay #(
    .LATENCY (LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (in_sb),
    .dout (aligned_sb)
  );

  // One extra bit catches the carry out of the accumulator.
  always_comb begin
    nsum  = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, MULT};
    sat   = nsum[ACC_W] | ovf;
    value = sat ? {ACC_W{1'b1}} : nsum[ACC_W-1:0];
    ncnt  = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      SUM       <= '0;
      SUM_CNT   <= '0;
      SUM_OVF   <= 1'b0;
      SUM_VALID <= 1'b0;
    end else begin
      SUM_VALID <= 1'b0;
      if (aligned_sb.valid) begin
        if (aligned_sb.last) begin
          // Close the frame and restart clean on the same edge.
          SUM       <= value;
          SUM_CNT   <= ncnt;
          SUM_OVF   <= sat;
          SUM_VALID <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else begin
          acc <= value;
          cnt <= ncnt;
          ovf <= sat;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_v_mult_accum.sv
// ============================================================================
// tb_v_mult_accum : directed self-checking bench with a pipelined multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_v_mult_accum;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_LAST  = 1'b0;
  logic [35:0] pin = '0;
  logic [35:0] mpipe [LAT];
  logic [35:0] MULT;

  logic [47:0] SUM;
  logic [15:0] SUM_CNT;
  logic        SUM_OVF;
  logic        SUM_VALID;

  logic [35:0] SUM36;
  logic [15:0] SUM_CNT36;
  logic        SUM_OVF36;
  logic        SUM_VALID36;

  int checks   = 0;
  int failures = 0;
  int pulses;

  always #5 clk = ~clk;

  // Reference multiplier: unreset LAT-stage pipe, output valid LAT-1 edges after sampling.
  always @(posedge clk) begin
    mpipe[0] <= pin;
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign MULT = mpipe[LAT-1];

  v_mult_accum #(.LATENCY(LAT), .PROD_W(36), .ACC_W(48), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .MULT(MULT),
    .SUM(SUM), .SUM_CNT(SUM_CNT), .SUM_OVF(SUM_OVF), .SUM_VALID(SUM_VALID)
  );

  v_mult_accum #(.LATENCY(LAT), .PROD_W(36), .ACC_W(36), .CNT_W(16)) dut36 (
    .clk(clk), .rst(rst), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST), .MULT(MULT),
    .SUM(SUM36), .SUM_CNT(SUM_CNT36), .SUM_OVF(SUM_OVF36), .SUM_VALID(SUM_VALID36)
  );

  function automatic logic [35:0] mul18(input logic [17:0] a, input logic [17:0] b);
    return 36'(a) * 36'(b);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [35:0] p);
    IN_VALID = v;
    IN_LAST  = l;
    pin      = p;
    @(posedge clk);
    #1;
  endtask

  // Idle edges, counting SUM_VALID pulses seen on the main DUT.
  task automatic idle(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 36'd0);
      if (SUM_VALID) seen++;
    end
  endtask

  initial begin
    // Reset state
    repeat (3) begin @(posedge clk); #1; end
    check("rst_sum", 64'(SUM), 64'd0);
    check("rst_cnt", 64'(SUM_CNT), 64'd0);
    check("rst_ovf", 64'(SUM_OVF), 64'd0);
    check("rst_valid", 64'(SUM_VALID), 64'd0);
    rst = 1'b0;
    idle(2, pulses);

    // 1: three-term dot product, pulse exactly LAT edges after LAST
    drive(1'b1, 1'b0, mul18(18'd3, 18'd4));
    drive(1'b1, 1'b0, mul18(18'd5, 18'd6));
    drive(1'b1, 1'b1, mul18(18'd7, 18'd8));
    idle(LAT - 1, pulses);
    check("t1_early_pulses", 64'(pulses), 64'd0);
    idle(1, pulses);
    check("t1_valid", 64'(SUM_VALID), 64'd1);
    check("t1_sum", 64'(SUM), 64'd98);
    check("t1_cnt", 64'(SUM_CNT), 64'd3);
    check("t1_ovf", 64'(SUM_OVF), 64'd0);
    idle(1, pulses);
    check("t1_valid_drop", 64'(SUM_VALID), 64'd0);
    check("t1_hold", 64'(SUM), 64'd98);

    // 2: back-to-back single-term frames
    drive(1'b1, 1'b1, 36'd10);
    drive(1'b1, 1'b1, 36'd20);
    drive(1'b1, 1'b1, 36'd30);
    idle(LAT - 3, pulses);
    check("t2_early_pulses", 64'(pulses), 64'd0);
    idle(1, pulses);
    check("t2_v0", 64'(SUM_VALID), 64'd1);
    check("t2_s0", 64'(SUM), 64'd10);
    check("t2_c0", 64'(SUM_CNT), 64'd1);
    idle(1, pulses);
    check("t2_v1", 64'(SUM_VALID), 64'd1);
    check("t2_s1", 64'(SUM), 64'd20);
    check("t2_c1", 64'(SUM_CNT), 64'd1);
    idle(1, pulses);
    check("t2_v2", 64'(SUM_VALID), 64'd1);
    check("t2_s2", 64'(SUM), 64'd30);
    check("t2_c2", 64'(SUM_CNT), 64'd1);
    idle(1, pulses);
    check("t2_v3", 64'(SUM_VALID), 64'd0);

    // 3: gaps inside a frame
    drive(1'b1, 1'b0, 36'd2);
    idle(3, pulses);
    drive(1'b1, 1'b0, 36'd4);
    idle(1, pulses);
    drive(1'b1, 1'b1, 36'd6);
    idle(LAT - 1, pulses);
    check("t3_early_pulses", 64'(pulses), 64'd0);
    idle(1, pulses);
    check("t3_valid", 64'(SUM_VALID), 64'd1);
    check("t3_sum", 64'(SUM), 64'd12);
    check("t3_cnt", 64'(SUM_CNT), 64'd3);

    // 4: overflow in the 36-bit build, then clean next frame
    drive(1'b1, 1'b0, 36'hF_FFFF_FFFF);
    drive(1'b1, 1'b1, 36'd5);
    idle(LAT, pulses);
    check("t4_valid36", 64'(SUM_VALID36), 64'd1);
    check("t4_sum36", 64'(SUM36), 64'h0000_000F_FFFF_FFFF);
    check("t4_ovf36", 64'(SUM_OVF36), 64'd1);
    check("t4_cnt36", 64'(SUM_CNT36), 64'd2);
    check("t4_sum48", 64'(SUM), 64'd68719476740);
    check("t4_ovf48", 64'(SUM_OVF), 64'd0);
    drive(1'b1, 1'b1, 36'd1);
    idle(LAT, pulses);
    check("t4_next_valid36", 64'(SUM_VALID36), 64'd1);
    check("t4_next_sum36", 64'(SUM36), 64'd1);
    check("t4_next_ovf36", 64'(SUM_OVF36), 64'd0);
    check("t4_next_cnt36", 64'(SUM_CNT36), 64'd1);

    // 5: reset mid-frame with four terms still in flight
    for (int i = 1; i <= 5; i++) drive(1'b1, 1'b0, 36'(i * 100));
    drive(1'b1, 1'b1, 36'd600);
    idle(1, pulses);
    rst = 1'b1;
    drive(1'b0, 1'b0, 36'd0);
    rst = 1'b0;
    check("t5_rst_sum", 64'(SUM), 64'd0);
    check("t5_rst_cnt", 64'(SUM_CNT), 64'd0);
    check("t5_rst_valid", 64'(SUM_VALID), 64'd0);
    check("t5_rst_sum36", 64'(SUM36), 64'd0);
    idle(LAT + 2, pulses);
    check("t5_no_pulses", 64'(pulses), 64'd0);
    check("t5_sum_zero", 64'(SUM), 64'd0);
    drive(1'b1, 1'b1, mul18(18'd3, 18'd3));
    idle(LAT, pulses);
    check("t5_post_valid", 64'(SUM_VALID), 64'd1);
    check("t5_post_sum", 64'(SUM), 64'd9);
    check("t5_post_cnt", 64'(SUM_CNT), 64'd1);

    // 6: LAST without VALID is ignored
    drive(1'b0, 1'b1, 36'd77);
    idle(LAT + 1, pulses);
    check("t6_no_pulse", 64'(pulses), 64'd0);
    check("t6_sum_hold", 64'(SUM), 64'd9);
    drive(1'b1, 1'b1, 36'd3);
    idle(LAT, pulses);
    check("t6_next_sum", 64'(SUM), 64'd3);
    check("t6_next_cnt", 64'(SUM_CNT), 64'd1);
    check("t6_next_pulses", 64'(pulses), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
